// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and the initiator.
// Contents: FSM state encoding, R/W bit values, ACK/NACK bit values, common widths.
package i2c_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR7_W   = 7;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic SET_READ_BIT  = 1'b1;
    localparam logic SET_WRITE_BIT = 1'b0;
    localparam logic ACK_BIT       = 1'b0;
    localparam logic NACK_BIT      = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_in_filter.sv
// Input conditioning for one I2C line: 2-FF synchroniser, optional glitch
// filter, and rise/fall flags of the conditioned level.
// Build option: `I2C_TARGET_GLITCH_FILTER_EN adds a FILTER_LEN-sample
// agreement filter after the synchroniser.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   raw         asynchronous pin input
//   level       conditioned line level (registered)
//   rise_c      level rose this clk (combinational)
//   fall_c      level fell this clk (combinational)
module i2c_in_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Idle I2C lines sit high, so everything resets to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // A zero-length filter is not a valid configuration.
    if (FILTER_LEN == 0) begin : g_bad_filter_len
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_q2 == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            filt_q <= sync_q2;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q2;
`endif

    // Previous conditioned sample for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target for the HDMI control bus. Detects START/STOP/repeated START,
// matches a 7-bit address, and bridges writes/reads onto a byte register port.
// SDA is open drain: sda_oe=1 pulls low, 0 releases.
// Build option: `I2C_TARGET_GLITCH_FILTER_EN enables the input glitch filter.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   scl_in, sda_in   raw bus pins
//   sda_oe           SDA pull-down enable
//   reg_wr, reg_rd   one-clk register write / fetch strobes
//   reg_addr         register pointer
//   reg_wdata        write data
//   reg_rdata        read data, valid the clk after reg_rd
//   busy             addressed transfer in progress
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR7_W-1:0] TARGET_ADDR = 7'h69,
    parameter int unsigned        FILTER_LEN  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [BYTE_W-1:0] reg_addr,
    output logic [BYTE_W-1:0] reg_wdata,
    input  logic [BYTE_W-1:0] reg_rdata,
    output logic              busy
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W);
    localparam logic [BIT_CNT_W-1:0] PRE_LAST = BIT_CNT_W'(BYTE_W - 1);

    logic scl_level, scl_rise_c, scl_fall_c;
    logic sda_level, sda_rise_c, sda_fall_c;
    logic start_c, stop_c;

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .reset  (reset),
        .raw    (scl_in),
        .level  (scl_level),
        .rise_c (scl_rise_c),
        .fall_c (scl_fall_c)
    );

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .reset  (reset),
        .raw    (sda_in),
        .level  (sda_level),
        .rise_c (sda_rise_c),
        .fall_c (sda_fall_c)
    );

    // An SDA edge coinciding with an SCL rise is a data bit, not a condition.
    assign start_c = sda_fall_c & scl_level & ~scl_rise_c;
    assign stop_c  = sda_rise_c & scl_level & ~scl_rise_c;

    i2c_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]      shift_q, shift_d;
    logic [BYTE_W-1:0]      shifted_c;
    logic                   rw_q, rw_d;
    logic                   first_byte_q, first_byte_d;
    logic                   sda_oe_d, reg_wr_d, reg_rd_d, busy_d;
    logic [BYTE_W-1:0]      reg_addr_d, reg_wdata_d;

    assign shifted_c = {shift_q[BYTE_W-2:0], sda_level};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rw_q         <= 1'b0;
            first_byte_q <= 1'b0;
            sda_oe       <= 1'b0;
            reg_wr       <= 1'b0;
            reg_rd       <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            first_byte_q <= first_byte_d;
            sda_oe       <= sda_oe_d;
            reg_wr       <= reg_wr_d;
            reg_rd       <= reg_rd_d;
            reg_addr     <= reg_addr_d;
            reg_wdata    <= reg_wdata_d;
            busy         <= busy_d;
        end
    end

    // Bus protocol: conditions first, then bit handling on SCL edges.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        first_byte_d = first_byte_q;
        sda_oe_d     = sda_oe;
        reg_wr_d     = 1'b0;
        reg_rd_d     = 1'b0;
        reg_addr_d   = reg_addr;
        reg_wdata_d  = reg_wdata;
        busy_d       = busy;

        // Pointer advances the clk after the write strobe so the strobe sees the old address.
        if (reg_wr) begin
            reg_addr_d = reg_addr + BYTE_W'(1);
        end

        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise_c) begin
                        shift_d   = shifted_c;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (scl_fall_c && bit_cnt_q == LAST_BIT) begin
                        if (shift_q[BYTE_W-1:1] == TARGET_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = ~ACK_BIT;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            reg_rd_d = (shift_q[0] == SET_READ_BIT);
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall_c) begin
                        if (rw_q == SET_WRITE_BIT) begin
                            state_d      = RX_BYTE;
                            sda_oe_d     = 1'b0;
                            bit_cnt_d    = '0;
                            first_byte_d = 1'b1;
                        end else begin
                            // First read bit goes out on the same SCL fall that ends the ACK.
                            state_d   = TX_BYTE;
                            sda_oe_d  = ~reg_rdata[BYTE_W-1];
                            shift_d   = {reg_rdata[BYTE_W-2:0], 1'b0};
                            bit_cnt_d = BIT_CNT_W'(1);
                        end
                    end
                end

                RX_BYTE: begin
                    if (scl_rise_c) begin
                        shift_d   = shifted_c;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == PRE_LAST) begin
                            if (first_byte_q) begin
                                reg_addr_d   = shifted_c;
                                first_byte_d = 1'b0;
                            end else begin
                                reg_wr_d    = 1'b1;
                                reg_wdata_d = shifted_c;
                            end
                        end
                    end else if (scl_fall_c && bit_cnt_q == LAST_BIT) begin
                        state_d  = RX_ACK;
                        sda_oe_d = ~ACK_BIT;
                    end
                end

                RX_ACK: begin
                    if (scl_fall_c) begin
                        state_d   = RX_BYTE;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end

                TX_BYTE: begin
                    if (scl_fall_c) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d  = TX_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d  = ~shift_q[BYTE_W-1];
                            shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end

                TX_ACK: begin
                    if (scl_rise_c) begin
                        if (sda_level == NACK_BIT) begin
                            state_d = WAIT_STOP;
                        end else begin
                            reg_addr_d = reg_addr + BYTE_W'(1);
                            reg_rd_d   = 1'b1;
                        end
                    end else if (scl_fall_c) begin
                        state_d   = TX_BYTE;
                        sda_oe_d  = ~reg_rdata[BYTE_W-1];
                        shift_d   = {reg_rdata[BYTE_W-2:0], 1'b0};
                        bit_cnt_d = BIT_CNT_W'(1);
                    end
                end

                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on an open-drain SDA,
// a register-file model answering reg_rd, and logs of strobes and SDA pulls.
module tb_i2c_target;

    localparam int Q = 25;   // clks per quarter SCL period

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam logic GLITCH_BUSY = 1'b1;
`else
    localparam logic GLITCH_BUSY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       sda_oe, reg_wr, reg_rd, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [256];
    logic [15:0] wr_log [$];
    logic [7:0]  rd_log [$];
    int          oe_cycles = 0;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    always #20 clk = ~clk;

    i2c_target dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register-file model and strobe logging.
    always @(posedge clk) begin
        if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
        if (reg_rd) begin
            rd_log.push_back(reg_addr);
            reg_rdata <= mem[reg_addr];
        end
        if (sda_oe) oe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wr_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 16'hxxxx;
    endfunction

    function automatic logic [7:0] rd_at(input int i);
        if (i < rd_log.size()) return rd_log[i];
        return 8'hxx;
    endfunction

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        i2c_start();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; qw();
        scl_m = 1'b1; qw(); qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        b = sda_in; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        send_bit(ack);
    endtask

    task automatic write_xfer(input logic [7:0] ptr, input logic [7:0] data, input string tag);
        logic a;
        i2c_start();
        send_byte(8'hD2, a); check({tag, "_ack_addr"}, 32'(a), 32'h0);
        send_byte(ptr, a);   check({tag, "_ack_ptr"}, 32'(a), 32'h0);
        send_byte(data, a);  check({tag, "_ack_data"}, 32'(a), 32'h0);
        i2c_stop();
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        logic [7:0] addr_w;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC3;

        // Reset state
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_reg_wr", 32'(reg_wr), 32'h0);
        check("rst_reg_rd", 32'(reg_rd), 32'h0);
        check("rst_reg_addr", 32'(reg_addr), 32'h0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 1: write 0xAB to register 0x10
        i2c_start();
        send_byte(8'hD2, a); check("t1_ack_addr", 32'(a), 32'h0);
        send_byte(8'h10, a); check("t1_ack_ptr", 32'(a), 32'h0);
        send_byte(8'hAB, a); check("t1_ack_data", 32'(a), 32'h0);
        check("t1_busy_mid", 32'(busy), 32'h1);
        i2c_stop();
        qw();
        check("t1_busy_end", 32'(busy), 32'h0);
        check("t1_wr_count", 32'(wr_log.size()), 32'd1);
        check("t1_wr0", 32'(wr_at(0)), 32'h10AB);
        check("t1_wdata", 32'(reg_wdata), 32'hAB);
        check("t1_addr_after", 32'(reg_addr), 32'h11);

        // 2: pointer 0x20, repeated START, read two bytes
        wr_log.delete(); rd_log.delete();
        i2c_start();
        send_byte(8'hD2, a); check("t2_ack_addr_w", 32'(a), 32'h0);
        send_byte(8'h20, a); check("t2_ack_ptr", 32'(a), 32'h0);
        i2c_rstart();
        send_byte(8'hD3, a); check("t2_ack_addr_r", 32'(a), 32'h0);
        read_byte(d, 1'b0);  check("t2_byte0", 32'(d), 32'h5A);
        read_byte(d, 1'b1);  check("t2_byte1", 32'(d), 32'hC3);
        i2c_stop();
        qw();
        check("t2_rd_count", 32'(rd_log.size()), 32'd2);
        check("t2_rd0", 32'(rd_at(0)), 32'h20);
        check("t2_rd1", 32'(rd_at(1)), 32'h21);
        check("t2_wr_count", 32'(wr_log.size()), 32'd0);
        check("t2_busy_end", 32'(busy), 32'h0);

        // 3: wrong address 0x50, then a valid write
        wr_log.delete(); rd_log.delete(); oe_cycles = 0;
        i2c_start();
        send_byte(8'hA0, a); check("t3_nack_addr", 32'(a), 32'h1);
        send_byte(8'h00, a); check("t3_nack_data", 32'(a), 32'h1);
        check("t3_busy_mid", 32'(busy), 32'h0);
        i2c_stop();
        qw();
        check("t3_oe_cycles", 32'(oe_cycles), 32'd0);
        check("t3_wr_count", 32'(wr_log.size()), 32'd0);
        check("t3_rd_count", 32'(rd_log.size()), 32'd0);
        write_xfer(8'h30, 8'h77, "t3b");
        qw();
        check("t3b_wr0", 32'(wr_at(0)), 32'h3077);

        // 4: pointer 0xFF, two data bytes wrap the pointer
        wr_log.delete();
        i2c_start();
        send_byte(8'hD2, a); check("t4_ack_addr", 32'(a), 32'h0);
        send_byte(8'hFF, a); check("t4_ack_ptr", 32'(a), 32'h0);
        send_byte(8'h11, a); check("t4_ack_d0", 32'(a), 32'h0);
        send_byte(8'h22, a); check("t4_ack_d1", 32'(a), 32'h0);
        i2c_stop();
        qw();
        check("t4_wr_count", 32'(wr_log.size()), 32'd2);
        check("t4_wr0", 32'(wr_at(0)), 32'hFF11);
        check("t4_wr1", 32'(wr_at(1)), 32'h0022);
        check("t4_addr_after", 32'(reg_addr), 32'h01);

        // 5: reset during the address ACK of a write
        wr_log.delete();
        addr_w = 8'hD2;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(addr_w[i]);
        sda_m = 1'b1; qw();
        check("t5_oe_in_ack", 32'(sda_oe), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_oe_after_rst", 32'(sda_oe), 32'h0);
        check("t5_busy_after_rst", 32'(busy), 32'h0);
        check("t5_addr_after_rst", 32'(reg_addr), 32'h00);
        check("t5_rd_after_rst", 32'(reg_rd), 32'h0);
        reset = 1'b0;
        qw();
        i2c_stop();
        write_xfer(8'h40, 8'h99, "t5b");
        qw();
        check("t5b_wr_count", 32'(wr_log.size()), 32'd1);
        check("t5b_wr0", 32'(wr_at(0)), 32'h4099);

        // 6: 2-clk SDA low glitch while SCL high inside an addressed write
        wr_log.delete();
        i2c_start();
        send_byte(8'hD2, a); check("t6_ack_addr", 32'(a), 32'h0);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b0;
        repeat (2) @(negedge clk);
        sda_m = 1'b1; qw();
        check("t6_busy_after_glitch", 32'(busy), 32'(GLITCH_BUSY));
        scl_m = 1'b0; qw();
        i2c_stop();
        qw();
        check("t6_busy_end", 32'(busy), 32'h0);
        check("t6_wr_count", 32'(wr_log.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
